// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory port between an instruction-fetch
// requester and a data requester. At most one access is in flight. Data has
// priority, but a streak counter bounds how long a waiting fetch can starve.
module mem_arbiter #(
   parameter int unsigned MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_flush,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   output logic        if_wait,
   // data port
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_ack,
   output logic [31:0] dm_rdata,
   output logic        dm_wait,
   // unified memory
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned SW = 3;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state;
   logic          owner_data;   // 1 = data port owns the access, 0 = fetch
   logic          drop;         // in-flight fetch was flushed
   logic [SW-1:0] streak;
   logic [31:0]   lat_addr;
   logic [31:0]   lat_wdata;
   logic          lat_we;
   logic          if_ack_r;

   logic fetch_elig;
   logic data_elig;
   logic grant_fetch;
   logic grant_data;

   // Grant decision: data first, unless the fetch has waited out the streak.
   always_comb begin
      fetch_elig  = if_req & ~if_flush;
      data_elig   = dm_req;
      grant_fetch = fetch_elig & (~data_elig | (streak == STREAK_MAX));
      grant_data  = data_elig & ~grant_fetch;
   end

   // Arbiter FSM with all datapath registers and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner_data <= 1'b0;
         drop       <= 1'b0;
         streak     <= '0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_we     <= 1'b0;
         if_ack_r   <= 1'b0;
         dm_ack     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_fetch || grant_data) begin
                  owner_data <= grant_data;
                  lat_addr   <= grant_data ? dm_addr : if_addr;
                  lat_we     <= grant_data & dm_we;
                  if (grant_data)
                     lat_wdata <= dm_wdata;
                  mem_req    <= 1'b1;
                  mem_we     <= grant_data & dm_we;
                  drop       <= 1'b0;
                  // Count data grants only while a fetch is actually waiting.
                  if (grant_data && fetch_elig) begin
                     if (streak != STREAK_MAX)
                        streak <= streak + SW'(1);
                  end else begin
                     streak <= '0;
                  end
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_data && if_flush)
                  drop <= 1'b1;
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (owner_data) begin
                     if (!lat_we)
                        dm_rdata <= mem_rdata;
                     dm_ack <= 1'b1;
                     state  <= RESP;
                  end else if (drop || if_flush) begin
                     // Flushed fetch: memory finished, result is discarded.
                     state <= IDLE;
                  end else begin
                     if_rdata <= mem_rdata;
                     if_ack_r <= 1'b1;
                     state    <= RESP;
                  end
               end
            end
            RESP: begin
               if_ack_r <= 1'b0;
               dm_ack   <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A flush arriving in the response cycle still cancels the fetch ack.
   assign if_ack    = if_ack_r & ~if_flush;
   assign if_wait   = if_req & ~if_ack & ~if_flush;
   assign dm_wait   = dm_req & ~dm_ack;
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: latency, priority, starvation bound,
// flush handling, wait states and asynchronous reset.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_flush, dm_req, dm_we, mem_ready;
   logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
   logic        if_ack, dm_ack, mem_req, mem_we, if_wait, dm_wait;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_ack(if_ack), .if_rdata(if_rdata), .if_wait(if_wait),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_wait(dm_wait),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expectation.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int dcnt;
   int d_before_f;
   int d_after_f;
   bit f_seen;

   initial begin
      reset = 1'b1;
      if_req = 0; if_flush = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
      if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
      #2;
      check("rst_mem_req", 32'(mem_req), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_if_ack", 32'(if_ack), 0);
      check("rst_dm_ack", 32'(dm_ack), 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_dm_rdata", dm_rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      step();
      reset = 1'b0;
      step();

      // Single fetch, minimum latency
      if_req = 1; if_addr = 32'h100; mem_ready = 1; mem_rdata = 32'h13;
      #1 check("f1_if_wait", 32'(if_wait), 1);
      check("f1_idle_mem_req", 32'(mem_req), 0);
      step();
      check("f1_mem_req", 32'(mem_req), 1);
      check("f1_mem_addr", mem_addr, 32'h100);
      check("f1_mem_we", 32'(mem_we), 0);
      step();
      check("f1_if_ack", 32'(if_ack), 1);
      check("f1_if_rdata", if_rdata, 32'h13);
      check("f1_if_wait_ack", 32'(if_wait), 0);
      check("f1_resp_mem_req", 32'(mem_req), 0);
      if_req = 0;
      step();
      check("f1_ack_one_cycle", 32'(if_ack), 0);

      // Simultaneous fetch and data write: data first
      if_req = 1; if_addr = 32'h104;
      dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
      mem_ready = 1; mem_rdata = 32'hAAAA5555;
      step();
      check("sim_mem_we", 32'(mem_we), 1);
      check("sim_mem_addr", mem_addr, 32'h200);
      check("sim_mem_wdata", mem_wdata, 32'hDEADBEEF);
      step();
      check("sim_dm_ack", 32'(dm_ack), 1);
      check("sim_dm_rdata_held", dm_rdata, 0);
      check("sim_no_if_ack", 32'(if_ack), 0);
      dm_req = 0; dm_we = 0;
      step();
      check("sim_idle_mem_req", 32'(mem_req), 0);
      step();
      check("sim_f_mem_addr", mem_addr, 32'h104);
      check("sim_f_mem_we", 32'(mem_we), 0);
      check("sim_f_wdata_hold", mem_wdata, 32'hDEADBEEF);
      step();
      check("sim_if_ack", 32'(if_ack), 1);
      check("sim_if_rdata", if_rdata, 32'hAAAA5555);
      if_req = 0;
      step();

      // Starvation bound: 4 data acks, then the fetch, then data again
      dm_req = 1; dm_we = 0; dm_addr = 32'h500;
      if_req = 1; if_addr = 32'h600;
      mem_ready = 1; mem_rdata = 32'h77;
      dcnt = 0; d_before_f = -1; d_after_f = 0; f_seen = 0;
      for (int c = 0; c < 60 && d_after_f == 0; c++) begin
         step();
         if (dm_ack) begin
            if (f_seen) d_after_f++;
            else dcnt++;
         end
         if (if_ack) begin
            d_before_f = dcnt;
            f_seen = 1;
            check("stv_if_rdata", if_rdata, 32'h77);
            if_req = 0;
         end
      end
      check("stv_data_before_fetch", 32'(d_before_f), 4);
      check("stv_data_resumed", 32'(d_after_f), 1);
      check("stv_dm_rdata", dm_rdata, 32'h77);
      dm_req = 0; if_req = 0;
      step();

      // Flush while the fetch is in BUSY
      if_req = 1; if_addr = 32'h300; mem_ready = 0; mem_rdata = 32'hBAD0BAD0;
      step();
      check("fl_mem_req", 32'(mem_req), 1);
      check("fl_mem_addr", mem_addr, 32'h300);
      step();
      if_flush = 1; if_req = 0;
      #1 check("fl_if_wait", 32'(if_wait), 0);
      step();
      if_flush = 0;
      check("fl_still_busy", 32'(mem_req), 1);
      mem_ready = 1;
      step();
      check("fl_no_if_ack", 32'(if_ack), 0);
      check("fl_idle", 32'(mem_req), 0);
      check("fl_if_rdata_held", if_rdata, 32'h77);
      mem_ready = 0;
      step();
      check("fl_no_late_ack", 32'(if_ack), 0);

      // Flush in the response cycle suppresses if_ack
      if_req = 1; if_addr = 32'h310; mem_ready = 1; mem_rdata = 32'h31;
      step();
      step();
      if_flush = 1; if_req = 0;
      #1 check("flr_ack_suppressed", 32'(if_ack), 0);
      step();
      if_flush = 0; mem_ready = 0;
      check("flr_idle", 32'(mem_req), 0);

      // Data read with 5 wait states
      dm_req = 1; dm_we = 0; dm_addr = 32'h400; mem_ready = 0;
      step();
      for (int i = 0; i < 5; i++) begin
         check("ws_mem_addr", mem_addr, 32'h400);
         check("ws_mem_req", 32'(mem_req), 1);
         check("ws_dm_wait", 32'(dm_wait), 1);
         check("ws_no_dm_ack", 32'(dm_ack), 0);
         step();
      end
      mem_ready = 1; mem_rdata = 32'h12345678;
      check("ws_last_addr", mem_addr, 32'h400);
      step();
      check("ws_dm_ack", 32'(dm_ack), 1);
      check("ws_dm_rdata", dm_rdata, 32'h12345678);
      check("ws_dm_wait_off", 32'(dm_wait), 0);
      dm_req = 0;
      step();
      check("ws_ack_one_cycle", 32'(dm_ack), 0);

      // mem_ready while idle is ignored
      mem_ready = 1; mem_rdata = 32'hFFFF0000;
      step();
      step();
      check("idle_rdy_no_ack", 32'(dm_ack), 0);
      check("idle_rdy_rdata", dm_rdata, 32'h12345678);
      mem_ready = 0;

      // Asynchronous reset in the middle of an access
      if_req = 1; if_addr = 32'h700;
      step();
      check("rma_busy", 32'(mem_req), 1);
      if_req = 0;
      #2 reset = 1;
      #1 check("rma_async_mem_req", 32'(mem_req), 0);
      check("rma_async_if_rdata", if_rdata, 0);
      check("rma_async_mem_addr", mem_addr, 0);
      step();
      reset = 0;
      mem_ready = 1;
      step();
      check("rma_no_ack_a", 32'(if_ack), 0);
      step();
      check("rma_no_ack_b", 32'(if_ack), 0);
      check("rma_idle", 32'(mem_req), 0);
      if_req = 1; if_addr = 32'h704; mem_rdata = 32'h99;
      step();
      check("rma_new_mem_addr", mem_addr, 32'h704);
      check("rma_new_mem_req", 32'(mem_req), 1);
      step();
      check("rma_new_if_ack", 32'(if_ack), 1);
      check("rma_new_if_rdata", if_rdata, 32'h99);
      if_req = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_DATA_STREAK, default 4: maximum consecutive data-port grants while a fetch request waits; legal range 1..7.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch read request; held high until if_ack or if_flush.
REQ-005 if_addr  input  32  fetch address.
REQ-006 if_flush  input  1  cancels any pending or in-flight fetch (pc redirect).
REQ-007 if_ack  output  1  one-cycle pulse; if_rdata valid.
REQ-008 if_rdata  output  32  fetched instruction word.
REQ-009 dm_req  input  1  data request; held high until dm_ack.
REQ-010 dm_we  input  1  1 = write, 0 = read.
REQ-011 dm_addr  input  32  data address.
REQ-012 dm_wdata  input  32  write data.
REQ-013 dm_ack  output  1  one-cycle completion pulse.
REQ-014 dm_rdata  output  32  load data.
REQ-015 mem_req  output  1  request to the unified memory.
REQ-016 mem_we  output  1  write enable to memory.
REQ-017 mem_addr  output  32  memory address.
REQ-018 mem_wdata  output  32  memory write data.
REQ-019 mem_ready  input  1  memory completes the current access this cycle.
REQ-020 mem_rdata  input  32  memory read data, valid when mem_ready=1.
REQ-021 if_wait  output  1  combinational: if_req & ~if_ack & ~if_flush (fetch stall).
REQ-022 dm_wait  output  1  combinational: dm_req & ~dm_ack (memory-stage stall).

Function
REQ-023 FSM states IDLE, BUSY, RESP; one access in flight at most.
REQ-024 IDLE: if a grant is eligible, latch owner, addr, we, wdata; go BUSY next cycle; else stay IDLE.
REQ-025 Eligibility: fetch eligible iff if_req & ~if_flush; data eligible iff dm_req.
REQ-026 Priority: data wins when both eligible, unless streak counter == MAX_DATA_STREAK, then fetch wins.
REQ-027 Streak counter (3 bits): +1 on data grant while fetch eligible; cleared on fetch grant or on data grant with fetch not eligible; saturates at MAX_DATA_STREAK.
REQ-028 BUSY: mem_req=1, mem_addr/mem_we/mem_wdata driven from latched values, stable until mem_ready; fetch owner drives mem_we=0.
REQ-029 BUSY with mem_ready=1: capture mem_rdata into owner's rdata register (reads only); go RESP, or IDLE if fetch owner dropped.
REQ-030 RESP: owner's ack=1 for exactly this cycle; requests ignored; next state IDLE.
REQ-031 Minimum latency: req in cycle N (IDLE), mem_req in N+1, mem_ready in N+1 gives ack in N+2.
REQ-032 if_flush while fetch owner in BUSY: set drop flag; access completes on memory; no if_ack; if_rdata unchanged; BUSY -> IDLE on mem_ready.
REQ-033 if_flush in RESP with fetch owner: if_ack suppressed that cycle.
REQ-034 if_flush never affects a data-owned access.
REQ-035 Data writes: dm_rdata unchanged; dm_ack still pulses.
REQ-036 mem_req=0 and mem_we=0 outside BUSY; mem_addr/mem_wdata hold last latched value.
REQ-037 mem_ready outside BUSY is ignored.

Reset
REQ-038 Reset asserted: state IDLE, streak 0, drop flag 0, latched addr/wdata/we 0, if_ack/dm_ack/mem_req/mem_we 0, if_rdata/dm_rdata 0 -- immediately, no clock needed.
REQ-039 Reset mid-BUSY abandons the access; no ack issued after release; first grant evaluated on the first rising edge after release.

Verification
REQ-040 Single fetch: if_req=1, if_addr=0x100, mem_ready tied 1, mem_rdata=0x00000013 -> mem_req at N+1, if_ack and if_rdata=0x13 at N+2, one cycle.
REQ-041 Simultaneous: if_req and dm_req (write 0x200, 0xDEADBEEF) in same cycle -> data granted first (mem_we=1, mem_wdata=0xDEADBEEF), dm_rdata unchanged, then fetch.
REQ-042 Starvation: dm_req held high continuously with if_req high, MAX_DATA_STREAK=4 -> exactly 4 dm_ack pulses, then if_ack, then data resumes.
REQ-043 Flush: fetch 0x300 in BUSY with mem_ready held 0 for 3 cycles, if_flush pulsed cycle 2 -> no if_ack, if_rdata unchanged, arbiter IDLE after mem_ready.
REQ-044 Wait states: dm read 0x400, mem_ready low 5 cycles then high with 0x12345678 -> mem_addr stable 0x400 throughout, dm_wait=1 throughout, dm_ack next cycle with dm_rdata=0x12345678.
REQ-045 Reset mid-access: reset asserted during BUSY -> mem_req=0 asynchronously, no ack after release, new if_req served normally.
